uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Receive-side companion of the UART TX controller. Takes bytes from the UART receiver, parses
//  host frames [HEADER][LEN][LEN payload bytes][SUM], and buffers the payload internally.
//  The payload is written to the downstream FIFO only when the checksum is good, so that
//  FIFO never holds bytes from a corrupt frame.
// PARAMETERS
//  HEADER       8'hAA   frame start byte
//  MAX_LEN      16      max payload bytes (1..255); sizes internal buffer
//  TIMEOUT_CYC  50000   inter-byte timeout in clk cycles (used only with timeout macro)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  asynchronous reset, active low
//  rx_data     in   8  byte from UART receiver, valid when rx_done=1
//  rx_done     in   1  one-cycle pulse per received byte
//  FIFO_full   in   1  downstream FIFO full
//  data8_out   out  8  payload byte to FIFO, valid when FIFO_wr=1
//  FIFO_wr     out  1  FIFO write strobe, one byte per high cycle
//  frame_ok    out  1  one-cycle pulse: frame committed
//  frame_err   out  1  one-cycle pulse: frame dropped (bad LEN, bad SUM, timeout)
//  rx_overrun  out  1  one-cycle pulse: byte arrived during COMMIT and was discarded
//  busy        out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; data8_out=0, FIFO_wr=0, frame_ok=0, frame_err=0, rx_overrun=0, busy=0;
//   byte index and checksum cleared. Reset mid-frame or mid-commit discards the frame with no pulse.
//  States and transitions (sampled on rx_done=1 unless stated):
//   IDLE     : rx_data==HEADER -> GET_LEN; any other byte is ignored silently.
//   GET_LEN  : LEN==0 or LEN>MAX_LEN -> frame_err pulse, IDLE; else store LEN, sum=LEN,
//              idx=0 -> GET_DATA.
//   GET_DATA : buf[idx]=rx_data, sum+=rx_data (8-bit, mod 256), idx++; when idx reaches LEN -> GET_SUM.
//   GET_SUM  : rx_data==sum -> COMMIT with idx=0; else frame_err pulse, IDLE.
//   COMMIT   : no rx_done needed. FIFO_wr = (state==COMMIT) && !FIFO_full, combinational;
//              data8_out = buf[idx]. idx++ on each write. After the write of byte LEN-1 -> IDLE
//              with frame_ok pulse on the following cycle. FIFO_full=1 stalls: no write, idx held.
//  Checksum: 8-bit sum of the LEN byte and all payload bytes. The HEADER byte is excluded.
//  A HEADER-valued byte inside LEN, payload or SUM is treated as data. No resync.
//  rx_done during COMMIT: byte discarded, rx_overrun pulses the next cycle, commit continues.
//  frame_ok, frame_err and rx_overrun are registered single-cycle pulses and are never high
//   together. Only one error can occur per frame.
//  Latency: first FIFO_wr is 1 cycle after the SUM byte's rx_done (if FIFO is not full). LEN bytes
//   take LEN cycles when the FIFO is never full.
// CONFIGURATION
//  UART_RX_TIMEOUT_EN defined: a counter is cleared on every rx_done and runs while in GET_LEN,
//   GET_DATA or GET_SUM. When it reaches TIMEOUT_CYC-1 -> frame_err pulse, IDLE, buffer discarded.
//   The counter is frozen in COMMIT.
//  UART_RX_TIMEOUT_EN undefined: no counter is present. A partial frame waits indefinitely.
// TESTING
//  1 AA 03 11 22 33 69, FIFO_full=0 -> FIFO_wr on 3 consecutive cycles with data 11,22,33;
//    frame_ok once; busy low afterwards.
//  2 AA 03 11 22 33 00 (bad SUM) -> frame_err once; zero FIFO_wr; back to IDLE; next good frame accepted.
//  3 AA 00, and AA 11 with MAX_LEN=16 -> frame_err right after LEN byte; the following bytes are
//    ignored until the next AA.
//  4 Good frame AA 02 5A A5 01, FIFO_full=1 for 5 cycles after the first write -> writes 5A,
//    then a 5-cycle stall, then A5; no loss, no duplicate.
//  5 Byte injected during COMMIT -> rx_overrun pulse; commit data unchanged; frame_ok.
//  6 With UART_RX_TIMEOUT_EN, TIMEOUT_CYC=100: AA 02 11 then silence -> frame_err 100 cycles
//    after the last rx_done. rst_n low mid-GET_DATA -> all outputs 0, no pulses.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses [HEADER][LEN][payload][SUM] frames and forwards the payload to a FIFO only when the checksum matches.
// Optional inter-byte timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       FIFO_full,
  output logic [7:0] data8_out,
  output logic       FIFO_wr,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       rx_overrun,
  output logic       busy
);
  localparam int         AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX8 = 8'(MAX_LEN);
  typedef enum logic [2:0] {IDLE, GET_LEN, GET_DATA, GET_SUM, COMMIT} state_t;
  state_t        state_q;
  logic [7:0]    len_q, sum_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    pay_q [2**AW];
  logic          frame_ok_q, frame_err_q, rx_overrun_q;
  logic          last, tmo;
  assign last       = 8'(idx_q) == len_q - 8'd1;
  assign FIFO_wr    = state_q == COMMIT && !FIFO_full;
  assign data8_out  = state_q == COMMIT ? pay_q[idx_q] : 8'h00;
  assign busy       = state_q != IDLE;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign rx_overrun = rx_overrun_q;
`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  assign tmo = (state_q == GET_LEN || state_q == GET_DATA || state_q == GET_SUM) && !rx_done
               && tmo_q == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else if (rx_done || state_q == IDLE) tmo_q <= '0;
    else if (state_q != COMMIT) tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (state_q == GET_DATA && rx_done) pay_q[idx_q] <= rx_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= 8'h00;
      sum_q        <= 8'h00;
      idx_q        <= '0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
      if (tmo) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (rx_done && rx_data == HEADER) state_q <= GET_LEN;
          GET_LEN: if (rx_done) begin
            if (rx_data == 8'h00 || rx_data > MAX8) begin
              state_q     <= IDLE;
              frame_err_q <= 1'b1;
            end else begin
              len_q   <= rx_data;
              sum_q   <= rx_data;
              idx_q   <= '0;
              state_q <= GET_DATA;
            end
          end
          GET_DATA: if (rx_done) begin
            sum_q <= sum_q + rx_data;
            idx_q <= idx_q + 1'b1;
            if (last) state_q <= GET_SUM;
          end
          GET_SUM: if (rx_done) begin
            if (rx_data == sum_q) begin
              idx_q   <= '0;
              state_q <= COMMIT;
            end else begin
              state_q     <= IDLE;
              frame_err_q <= 1'b1;
            end
          end
          COMMIT: begin
            if (!FIFO_full) begin
              idx_q <= idx_q + 1'b1;
              if (last) begin
                state_q    <= IDLE;
                frame_ok_q <= 1'b1;
              end
            end
            // a stray byte on the final write yields to frame_ok so pulses stay exclusive
            if (rx_done && !(!FIFO_full && last)) rx_overrun_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and randomized frames checked against a frame-level reference model.
module tb_uart_rx_frame_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, rx_done = 1'b0, FIFO_full = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] data8_out;
  logic       FIFO_wr, frame_ok, frame_err, rx_overrun, busy;
  int n_chk = 0, n_fail = 0, cyc_n = 0;
  int n_wr = 0, n_ok = 0, n_err = 0, n_ovr = 0, s_wr, s_ok, s_err, s_ovr;
  int first_wr = -1, last_wr = -1, ok_cyc = -1, err_cyc = -1, ovr_cyc = -1;
  logic [7:0] exp_q [$];

  uart_rx_frame_ctrl #(.HEADER(8'hAA), .MAX_LEN(16), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .FIFO_full(FIFO_full),
    .data8_out(data8_out), .FIFO_wr(FIFO_wr), .frame_ok(frame_ok), .frame_err(frame_err),
    .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle's inputs, sample just after the falling edge, then advance one clock
  task automatic cyc(input logic d, input logic [7:0] b, input logic f);
    rx_done = d; rx_data = b; FIFO_full = f;
    #1;
    if (FIFO_wr) begin
      if (first_wr < 0) first_wr = cyc_n;
      last_wr = cyc_n;
      n_wr++;
      chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("wr_data", 32'(data8_out), 32'(exp_q.pop_front()));
    end
    if (frame_ok)   begin n_ok++;  ok_cyc  = cyc_n; end
    if (frame_err)  begin n_err++; err_cyc = cyc_n; end
    if (rx_overrun) begin n_ovr++; ovr_cyc = cyc_n; end
    chk("pulse_excl", 32'($onehot0({frame_ok, frame_err, rx_overrun})), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic idle_n(input int n, input bit rf);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rf ? 1'($urandom_range(0, 9) < 3) : 1'b0);
  endtask

  task automatic drain(input string tag, input bit rf);
    int g;
    g = 0;
    while (busy && g < 400) begin
      cyc(1'b0, 8'h00, rf ? 1'($urandom_range(0, 9) < 3) : 1'b0);
      g++;
    end
    chk({tag, "_drain"}, 32'(g < 400), 32'd1);
    idle_n(2, 1'b0);
  endtask

  task automatic snap();
    s_wr = n_wr; s_ok = n_ok; s_err = n_err; s_ovr = n_ovr;
    first_wr = -1; last_wr = -1;
  endtask

  task automatic deltas(input string tag, input int ok, input int err, input int wr, input int ovr);
    chk({tag, "_ok"},  n_ok - s_ok, ok);
    chk({tag, "_err"}, n_err - s_err, err);
    chk({tag, "_wr"},  n_wr - s_wr, wr);
    chk({tag, "_ovr"}, n_ovr - s_ovr, ovr);
    chk({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int sc, lc, ic, len, nz;
    bit bad, valid;
    logic [7:0] s, b;
    logic [7:0] p [$];
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", 32'({data8_out, FIFO_wr, frame_ok, frame_err, rx_overrun, busy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    snap();
    exp_q = '{8'h11, 8'h22, 8'h33};
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    sc = cyc_n;
    send(8'h69);
    drain("t1", 1'b0);
    chk("t1_latency", first_wr - sc, 1);
    chk("t1_consecutive", last_wr - first_wr, 2);
    chk("t1_ok_timing", ok_cyc - last_wr, 1);
    chk("t1_busy", 32'(busy), 32'd0);
    deltas("t1", 1, 0, 3, 0);

    snap();
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    drain("t2_bad", 1'b0);
    deltas("t2_bad", 0, 1, 0, 0);
    snap();
    exp_q = '{8'h11, 8'h22, 8'h33};
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    drain("t2_good", 1'b0);
    deltas("t2_good", 1, 0, 3, 0);

    snap();
    send(8'hAA);
    lc = cyc_n;
    send(8'h00);
    idle_n(1, 1'b0);
    chk("t3_len0_timing", err_cyc - lc, 1);
    send(8'h11); send(8'h22);
    send(8'hAA);
    lc = cyc_n;
    send(8'h11);
    idle_n(1, 1'b0);
    chk("t3_len17_timing", err_cyc - lc, 1);
    send(8'h03); send(8'h01); send(8'h02); send(8'h06);
    chk("t3_ignored_busy", 32'(busy), 32'd0);
    drain("t3", 1'b0);
    deltas("t3", 0, 2, 0, 0);

    snap();
    exp_q = '{8'h5A, 8'hA5};
    send(8'hAA); send(8'h02); send(8'h5A); send(8'hA5);
    sc = cyc_n;
    send(8'h01);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    drain("t4", 1'b0);
    chk("t4_latency", first_wr - sc, 1);
    chk("t4_stall_span", last_wr - first_wr, 6);
    deltas("t4", 1, 0, 2, 0);

    snap();
    exp_q = '{8'h11, 8'h22, 8'h33};
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    ic = cyc_n;
    cyc(1'b1, 8'h55, 1'b0);
    drain("t5", 1'b0);
    chk("t5_ovr_timing", ovr_cyc - ic, 1);
    deltas("t5", 1, 0, 3, 1);

    snap();
    send(8'hAA); send(8'h02);
    lc = cyc_n;
    send(8'h11);
    idle_n(150, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    chk("t6_timeout_timing", err_cyc - lc, 101);
    chk("t6_timeout_busy", 32'(busy), 32'd0);
    deltas("t6_timeout", 0, 1, 0, 0);
`else
    chk("t6_wait_busy", 32'(busy), 32'd1);
    exp_q = '{8'h11, 8'h22};
    send(8'h22); send(8'h35);
    drain("t6_wait", 1'b0);
    deltas("t6_wait", 1, 0, 2, 0);
`endif

    snap();
    send(8'hAA); send(8'h03); send(8'h11);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({data8_out, FIFO_wr, frame_ok, frame_err, rx_overrun, busy}), 32'd0);
    @(negedge clk);
    idle_n(3, 1'b0);
    rst_n = 1'b1;
    deltas("rst_mid", 0, 0, 0, 0);
    exp_q = '{8'h11, 8'h22, 8'h33};
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    drain("rst_after", 1'b0);
    deltas("rst_after", 1, 0, 3, 0);

    for (int f = 0; f < 24; f++) begin
      nz = $urandom_range(0, 2);
      for (int i = 0; i < nz; i++) begin
        b = 8'($urandom);
        send(b == 8'hAA ? 8'h55 : b);
      end
      snap();
      len = $urandom_range(0, 19);
      bad = $urandom_range(0, 4) == 0;
      valid = len >= 1 && len <= 16;
      p.delete();
      s = 8'(len);
      for (int i = 0; i < len; i++) begin
        p.push_back(8'($urandom));
        s = s + p[i];
      end
      if (bad) s = s + 8'($urandom_range(1, 255));
      if (valid && !bad) foreach (p[i]) exp_q.push_back(p[i]);
      send(8'hAA);
      idle_n($urandom_range(0, 2), 1'b1);
      send(8'(len));
      if (valid) begin
        foreach (p[i]) begin
          send(p[i]);
          idle_n($urandom_range(0, 2), 1'b1);
        end
        send(s);
      end
      drain("rnd", 1'b1);
      deltas("rnd", int'(valid && !bad), int'(!(valid && !bad)), (valid && !bad) ? len : 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
